im_loader: RTL and testbench

- Boot-time program loader and sequencer for the instruction memory.
- Accepts a byte stream over a valid/ready handshake: a 16-bit little-endian word count, then the program bytes.
- Packs the bytes into 32-bit little-endian words and drives the instruction memory write port (`we`, `IM_addr`, `data`).
- Holds the CPU via `cpu_hold` until the whole program is written. Instruction-memory read data is invalid while `we` is high, so the core must not fetch during loading.

---
 rtl/im_loader.sv | 182 ++++++++++++++++++
 tb/tb_im_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: receives a little-endian word count and
// program bytes, packs them into 32-bit words and holds the CPU until loading ends.
module im_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [DATA_WIDTH-1:0] im_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_BYTES = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [15:0]           MAX_WORDS = 16'(DEPTH / 4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

    state_t                state_r, state_s;
    logic [15:0]           len_r, len_s;
    logic [1:0]            byte_cnt_r, byte_cnt_s;
    logic                  im_we_s;
    logic [ADDR_WIDTH-1:0] im_addr_s;
    logic [DATA_WIDTH-1:0] im_data_s;
    logic                  cpu_hold_s;
    logic                  busy_s;
    logic                  done_s;
    logic                  err_s;
    logic [15:0]           words_loaded_s;
    logic                  xfer_s;
    logic [15:0]           hdr_len_s;
    logic [15:0]           words_inc_s;

    // Byte acceptance is a pure state decode so it reacts in the same cycle.
    always_comb begin
        in_ready = 1'b0;
        case (state_r)
            S_HDR0, S_HDR1, S_BYTES: in_ready = 1'b1;
            default:                 in_ready = 1'b0;
        endcase
    end

    assign xfer_s      = in_valid && in_ready;
    assign hdr_len_s   = {in_byte, len_r[7:0]};
    assign words_inc_s = words_loaded + 16'd1;

    // Next-state and next-output decode; every output is captured in a flop.
    always_comb begin
        state_s        = state_r;
        len_s          = len_r;
        byte_cnt_s     = byte_cnt_r;
        im_we_s        = 1'b0;
        im_addr_s      = im_addr;
        im_data_s      = im_data;
        cpu_hold_s     = cpu_hold;
        busy_s         = busy;
        done_s         = done;
        err_s          = err;
        words_loaded_s = words_loaded;

        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_s        = S_HDR0;
                    busy_s         = 1'b1;
                    cpu_hold_s     = 1'b1;
                    done_s         = 1'b0;
                    err_s          = 1'b0;
                    words_loaded_s = 16'd0;
                    im_addr_s      = '0;
                    byte_cnt_s     = 2'd0;
                end else begin
                    state_s = state_r;
                end
            end
            S_HDR0: begin
                if (xfer_s) begin
                    len_s[7:0] = in_byte;
                    state_s    = S_HDR1;
                end else begin
                    state_s = S_HDR0;
                end
            end
            S_HDR1: begin
                if (xfer_s) begin
                    len_s[15:8] = in_byte;
                    if (hdr_len_s == 16'd0) begin
                        state_s    = S_DONE;
                        done_s     = 1'b1;
                        busy_s     = 1'b0;
                        cpu_hold_s = 1'b0;
                    end else if (hdr_len_s > MAX_WORDS) begin
                        state_s = S_ERR;
                        err_s   = 1'b1;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = S_BYTES;
                    end
                end else begin
                    state_s = S_HDR1;
                end
            end
            S_BYTES: begin
                if (xfer_s) begin
                    im_data_s[{byte_cnt_r, 3'b000} +: 8] = in_byte;
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        state_s = S_WRITE;
                        im_we_s = 1'b1;
                    end else begin
                        state_s = S_BYTES;
                    end
                end else begin
                    state_s = S_BYTES;
                end
            end
            S_WRITE: begin
                words_loaded_s = words_inc_s;
                im_addr_s      = im_addr + ADDR_STEP;
                if (words_inc_s == len_r) begin
                    state_s    = S_DONE;
                    done_s     = 1'b1;
                    busy_s     = 1'b0;
                    cpu_hold_s = 1'b0;
                end else begin
                    state_s = S_BYTES;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            len_r        <= 16'd0;
            byte_cnt_r   <= 2'd0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_data      <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            byte_cnt_r   <= byte_cnt_s;
            im_we        <= im_we_s;
            im_addr      <= im_addr_s;
            im_data      <= im_data_s;
            cpu_hold     <= cpu_hold_s;
            busy         <= busy_s;
            done         <= done_s;
            err          <= err_s;
            words_loaded <= words_loaded_s;
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader: write-port scoreboard plus
// end-state checks for normal, backpressured, boundary and restart loads.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_w;
    logic [7:0] stream[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         xfer_cyc = 0;
    int         hdr_cyc = 0;
    int         end_cyc = 0;

    im_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(128)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write-port scoreboard: every im_we cycle must match the next expected write.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            check_eq("we_in_ready_low", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_we", 32'(im_we), 32'd0);
            end else begin
                mon_w = exp_q.pop_front();
                check_eq("wr_addr", im_addr, mon_w.addr);
                check_eq("wr_data", im_data, mon_w.data);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
            xfer_cyc = cyc;
        end
    endtask

    task automatic send_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_stream(input bit gaps);
        for (int i = 0; i < stream.size(); i++) begin
            if (gaps && i > 0) send_gap($urandom_range(1, 3));
            send_byte(stream[i]);
            if (i == 0) hdr_cyc = xfer_cyc;
        end
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && err !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1 && err !== 1'b1) check_eq(tag, 32'(done | err), 32'd1);
        end_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'hA5;
        repeat (3) @(negedge clk);
        check_eq("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check_eq("rst_im_we", 32'(im_we), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_words", 32'(words_loaded), 32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;

        // Two-word load, continuous stream.
        push_wr(32'h0, 32'h00100513);
        push_wr(32'h4, 32'h00200593);
        pulse_start();
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        send_stream(1'b0);
        wait_end("two_word_timeout");
        check_eq("two_word_done", 32'(done), 32'd1);
        check_eq("two_word_hold", 32'(cpu_hold), 32'd0);
        check_eq("two_word_busy", 32'(busy), 32'd0);
        check_eq("two_word_words", 32'(words_loaded), 32'd2);
        check_eq("two_word_cycles", 32'(end_cyc - hdr_cyc + 1), 32'd12);
        check_eq("two_word_all_writes", 32'(exp_q.size()), 32'd0);

        // Same stream with random gaps between bytes.
        push_wr(32'h0, 32'h00100513);
        push_wr(32'h4, 32'h00200593);
        pulse_start();
        send_stream(1'b1);
        wait_end("bp_timeout");
        check_eq("bp_done", 32'(done), 32'd1);
        check_eq("bp_words", 32'(words_loaded), 32'd2);
        check_eq("bp_all_writes", 32'(exp_q.size()), 32'd0);

        // Zero-length program.
        pulse_start();
        stream = '{8'h00, 8'h00};
        send_stream(1'b0);
        wait_end("zero_timeout");
        check_eq("zero_done", 32'(done), 32'd1);
        check_eq("zero_words", 32'(words_loaded), 32'd0);
        check_eq("zero_hold", 32'(cpu_hold), 32'd0);

        // 33 words exceeds a 128-byte memory.
        pulse_start();
        stream = '{8'h21, 8'h00};
        send_stream(1'b0);
        wait_end("big_timeout");
        repeat (2) @(negedge clk);
        check_eq("big_err", 32'(err), 32'd1);
        check_eq("big_done", 32'(done), 32'd0);
        check_eq("big_hold", 32'(cpu_hold), 32'd1);
        check_eq("big_busy", 32'(busy), 32'd0);
        check_eq("big_in_ready", 32'(in_ready), 32'd0);

        // Full memory: 32 words, byte i = i.
        stream = '{8'h20, 8'h00};
        for (int w = 0; w < 32; w++) begin
            push_wr(32'(w * 4), {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)});
            for (int b = 0; b < 4; b++) stream.push_back(8'(4 * w + b));
        end
        pulse_start();
        send_stream(1'b0);
        wait_end("full_timeout");
        check_eq("full_done", 32'(done), 32'd1);
        check_eq("full_err", 32'(err), 32'd0);
        check_eq("full_words", 32'(words_loaded), 32'd32);
        check_eq("full_all_writes", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a word abandons the load.
        pulse_start();
        stream = '{8'h01, 8'h00, 8'h11, 8'h22};
        send_stream(1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_hold", 32'(cpu_hold), 32'd1);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("midrst_no_we", 32'(im_we), 32'd0);
        push_wr(32'h0, 32'h44332211);
        pulse_start();
        stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(1'b0);
        wait_end("reload_timeout");
        check_eq("reload_done", 32'(done), 32'd1);
        check_eq("reload_words", 32'(words_loaded), 32'd1);

        // Start during BYTES is ignored.
        push_wr(32'h0, 32'h8899AABB);
        pulse_start();
        stream = '{8'h01, 8'h00, 8'hBB, 8'hAA};
        send_stream(1'b0);
        pulse_start();
        check_eq("ign_start_busy", 32'(busy), 32'd1);
        check_eq("ign_start_in_ready", 32'(in_ready), 32'd1);
        stream = '{8'h99, 8'h88};
        send_stream(1'b0);
        wait_end("ign_start_timeout");
        check_eq("ign_start_done", 32'(done), 32'd1);
        check_eq("ign_start_words", 32'(words_loaded), 32'd1);

        // Start from DONE restarts and overwrites from address 0.
        pulse_start();
        check_eq("restart_done", 32'(done), 32'd0);
        check_eq("restart_hold", 32'(cpu_hold), 32'd1);
        check_eq("restart_busy", 32'(busy), 32'd1);
        check_eq("restart_words", 32'(words_loaded), 32'd0);
        push_wr(32'h0, 32'hDDCCBBAA);
        stream = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_stream(1'b0);
        wait_end("restart_timeout");
        check_eq("restart_end_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("final_all_writes", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
